// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID (word 0) and build timestamp (word 1)
// from the sysid slave, compares both against expected constants and reports the result.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h575D_2765,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_ID = 3'd1,
        LAT_ID = 3'd2,
        REQ_TS = 3'd3,
        LAT_TS = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [7:0] TO_LIMIT   = TIMEOUT_CYCLES[7:0];
    localparam int         LAT_LAST_I = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam logic [1:0] LAT_LAST   = LAT_LAST_I[1:0];
    localparam bit         HAS_LAT    = (READ_LATENCY != 0);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [7:0]  stall_cnt_s;
    logic        auto_q, auto_d;
    logic        m_read_q, m_read_d;
    logic        m_address_q, m_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    // Next-state, capture and flag logic; bus outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        to_cnt_d    = to_cnt_q;
        auto_d      = 1'b0;
        done_d      = done_q;
        id_ok_d     = id_ok_q;
        ts_ok_d     = ts_ok_q;
        timeout_d   = timeout_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        stall_cnt_s = sat_inc(to_cnt_q);

        case (state_q)
            IDLE, DONE: begin
                if (start || auto_q) begin
                    state_d   = REQ_ID;
                    done_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    to_cnt_d  = 8'd0;
                    lat_cnt_d = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            REQ_ID: begin
                if (m_waitrequest) begin
                    to_cnt_d = stall_cnt_s;
                    if (stall_cnt_s >= TO_LIMIT) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = REQ_ID;
                    end
                end else if (HAS_LAT) begin
                    state_d   = LAT_ID;
                    lat_cnt_d = 2'd0;
                end else begin
                    id_value_d = m_readdata;
                    to_cnt_d   = 8'd0;
                    state_d    = REQ_TS;
                end
            end
            LAT_ID: begin
                if (lat_cnt_q == LAT_LAST) begin
                    id_value_d = m_readdata;
                    to_cnt_d   = 8'd0;
                    state_d    = REQ_TS;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            REQ_TS: begin
                if (m_waitrequest) begin
                    to_cnt_d = stall_cnt_s;
                    if (stall_cnt_s >= TO_LIMIT) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                        id_ok_d   = (id_value_q == EXPECTED_ID);
                        ts_ok_d   = 1'b0;
                    end else begin
                        state_d = REQ_TS;
                    end
                end else if (HAS_LAT) begin
                    state_d   = LAT_TS;
                    lat_cnt_d = 2'd0;
                end else begin
                    ts_value_d = m_readdata;
                    to_cnt_d   = 8'd0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    id_ok_d    = (id_value_q == EXPECTED_ID);
                    ts_ok_d    = (m_readdata == EXPECTED_TS);
                end
            end
            LAT_TS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    ts_value_d = m_readdata;
                    to_cnt_d   = 8'd0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    id_ok_d    = (id_value_q == EXPECTED_ID);
                    ts_ok_d    = (m_readdata == EXPECTED_TS);
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d == REQ_ID) || (state_d == LAT_ID) ||
                      (state_d == REQ_TS) || (state_d == LAT_TS);
        m_read_d    = (state_d == REQ_ID) || (state_d == REQ_TS);
        m_address_d = (state_d == REQ_TS);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 2'd0;
            to_cnt_q    <= 8'd0;
            auto_q      <= AUTO_START;
            m_read_q    <= 1'b0;
            m_address_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            timeout_q   <= 1'b0;
            id_value_q  <= 32'h0000_0000;
            ts_value_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            to_cnt_q    <= to_cnt_d;
            auto_q      <= auto_d;
            m_read_q    <= m_read_d;
            m_address_q <= m_address_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            id_ok_q     <= id_ok_d;
            ts_ok_q     <= ts_ok_d;
            timeout_q   <= timeout_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
        end
    end

    assign m_read    = m_read_q;
    assign m_address = m_address_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign id_ok     = id_ok_q;
    assign ts_ok     = ts_ok_q;
    assign timeout   = timeout_q;
    assign id_value  = id_value_q;
    assign ts_value  = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Two checkers (read latency 0 / timeout 4, and read latency 2 / timeout 255) share stimulus;
// a reactive slave model serves each, and a scoreboard compares every completed sequence.
module tb_sysid_checker;

    localparam logic [31:0] EID = 32'h0000_0000;
    localparam logic [31:0] ETS = 32'h575D_2765;

    typedef struct {
        int          dut;
        logic [31:0] idv;
        logic [31:0] tsv;
        logic [2:0]  flags;
        int          lat;
        int          reads;
        int          t0;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        m_address_s [2];
    logic        m_read_s    [2];
    logic        wr_s        [2];
    logic [31:0] rdata_s     [2];
    logic        busy_s      [2];
    logic        done_s      [2];
    logic        id_ok_s     [2];
    logic        ts_ok_s     [2];
    logic        timeout_s   [2];
    logic [31:0] id_value_s  [2];
    logic [31:0] ts_value_s  [2];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] w0 = 32'h0000_0000;
    logic [31:0] w1 = 32'h0000_0000;
    int          plan_id = 0;
    int          plan_ts = 0;
    int          wcnt [2];
    logic        pv1 = 1'b0, pv2 = 1'b0, pa1 = 1'b0, pa2 = 1'b0;
    logic [31:0] junk = 32'hDEAD_BEEF;
    logic [31:0] last_id [2];
    logic [31:0] last_ts [2];
    exp_t        sb [$];

    always #5 clock = ~clock;

    sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .READ_LATENCY(0),
                    .TIMEOUT_CYCLES(4), .AUTO_START(1'b1)) dut0 (
        .clock(clock), .reset(reset), .start(start),
        .m_address(m_address_s[0]), .m_read(m_read_s[0]),
        .m_waitrequest(wr_s[0]), .m_readdata(rdata_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .id_ok(id_ok_s[0]), .ts_ok(ts_ok_s[0]),
        .timeout(timeout_s[0]), .id_value(id_value_s[0]), .ts_value(ts_value_s[0])
    );

    sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .READ_LATENCY(2),
                    .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) dut1 (
        .clock(clock), .reset(reset), .start(start),
        .m_address(m_address_s[1]), .m_read(m_read_s[1]),
        .m_waitrequest(wr_s[1]), .m_readdata(rdata_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .id_ok(id_ok_s[1]), .ts_ok(ts_ok_s[1]),
        .timeout(timeout_s[1]), .id_value(id_value_s[1]), .ts_value(ts_value_s[1])
    );

    // Slave: stall each read for the planned number of cycles; data only in its valid window.
    assign wr_s[0]    = m_read_s[0] && (wcnt[0] < (m_address_s[0] ? plan_ts : plan_id));
    assign wr_s[1]    = m_read_s[1] && (wcnt[1] < (m_address_s[1] ? plan_ts : plan_id));
    assign rdata_s[0] = (m_read_s[0] && !wr_s[0]) ? (m_address_s[0] ? w1 : w0) : junk;
    assign rdata_s[1] = pv2 ? (pa2 ? w1 : w0) : junk;

    always @(posedge clock) begin
        cyc  <= cyc + 1;
        junk <= $urandom;
        pv1  <= m_read_s[1] && !wr_s[1];
        pa1  <= m_address_s[1];
        pv2  <= pv1;
        pa2  <= pa1;
        for (int d = 0; d < 2; d++) begin
            wcnt[d] <= (m_read_s[d] && wr_s[d]) ? wcnt[d] + 1 : 0;
        end
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s dut%0d: actual %0h required %0h", nm, d, act, req);
        end
    endtask

    // Reference: outcome of one check sequence from the stall plan and slave contents.
    function automatic exp_t model(input int d, input int t);
        exp_t e;
        int   rl;
        int   eff;
        rl      = (d == 0) ? 0 : 2;
        eff     = (d == 0) ? 4 : 255;
        e.dut   = d;
        e.t0    = t;
        e.idv   = last_id[d];
        e.tsv   = last_ts[d];
        e.flags = 3'b000;
        if (plan_id >= eff) begin
            e.flags = 3'b001;
            e.lat   = eff;
            e.reads = eff;
        end else begin
            e.idv = w0;
            if (plan_ts >= eff) begin
                e.flags = {(w0 == EID), 1'b0, 1'b1};
                e.lat   = 1 + rl + plan_id + eff;
                e.reads = 1 + plan_id + eff;
            end else begin
                e.tsv   = w1;
                e.flags = {(w0 == EID), (w1 == ETS), 1'b0};
                e.lat   = 2 * (1 + rl) + plan_id + plan_ts;
                e.reads = 2 + plan_id + plan_ts;
            end
        end
        last_id[d] = e.idv;
        last_ts[d] = e.tsv;
        return e;
    endfunction

    task automatic check_zero_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_flags", d, {m_read_s[d], m_address_s[d], busy_s[d], done_s[d],
                                 id_ok_s[d], ts_ok_s[d], timeout_s[d]}, 64'd0);
            chk("rst_values", d, {id_value_s[d], ts_value_s[d]}, 64'd0);
        end
    endtask

    task automatic launch(input bit via_reset, input bit poke);
        int t;
        @(negedge clock);
        if (via_reset) begin
            reset = 1'b0;
        end else begin
            start = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
        t = cyc;
        sb.push_back(model(0, t));
        sb.push_back(model(1, t));
        if (poke) begin
            start = 1'b1;
            chk("busy_on_poke", 0, busy_s[0], 1'b1);
            chk("busy_on_poke", 1, busy_s[1], 1'b1);
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("seq_drain", 0, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each rising done.
    initial begin
        logic done_prev  [2];
        logic stall_prev [2];
        logic addr_prev  [2];
        int   nreads     [2];
        int   idx;
        exp_t e;
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    done_prev[d]  = 1'b0;
                    stall_prev[d] = 1'b0;
                    addr_prev[d]  = 1'b0;
                    nreads[d]     = 0;
                end else begin
                    if (m_read_s[d]) begin
                        nreads[d]++;
                        chk("read_implies_busy", d, busy_s[d], 1'b1);
                    end
                    if (busy_s[d]) chk("done_while_busy", d, done_s[d], 1'b0);
                    if (stall_prev[d] && !(done_s[d] && timeout_s[d]))
                        chk("stall_hold", d, {m_read_s[d], m_address_s[d]}, {1'b1, addr_prev[d]});
                    if (done_s[d] && !done_prev[d]) begin
                        idx = -1;
                        foreach (sb[k]) if (idx < 0 && sb[k].dut == d) idx = k;
                        if (idx < 0) begin
                            chk("unexpected_done", d, 1'b1, 1'b0);
                        end else begin
                            e = sb[idx];
                            sb.delete(idx);
                            chk("id_value", d, id_value_s[d], e.idv);
                            chk("ts_value", d, ts_value_s[d], e.tsv);
                            chk("idok_tsok_timeout", d, {id_ok_s[d], ts_ok_s[d], timeout_s[d]}, e.flags);
                            chk("latency", d, cyc - e.t0, e.lat);
                            chk("read_cycles", d, nreads[d], e.reads);
                            chk("busy_read_at_done", d, {busy_s[d], m_read_s[d]}, 2'b00);
                        end
                        nreads[d] = 0;
                    end
                    done_prev[d]  = done_s[d];
                    stall_prev[d] = m_read_s[d] && wr_s[d];
                    addr_prev[d]  = m_address_s[d];
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            last_id[d] = 32'h0000_0000;
            last_ts[d] = 32'h0000_0000;
        end
        repeat (3) @(negedge clock);
        check_zero_outputs();

        w0 = EID; w1 = ETS; plan_id = 0; plan_ts = 0;
        launch(1'b1, 1'b0); drain();
        w1 = 32'h575D_2766;
        launch(1'b0, 1'b0); drain();
        w1 = ETS; plan_id = 3;
        launch(1'b0, 1'b1); drain();
        plan_id = 20;
        launch(1'b0, 1'b0); drain();
        plan_id = 0; plan_ts = 5; w0 = 32'h1234_5678;
        launch(1'b0, 1'b1); drain();
        plan_id = 300; plan_ts = 0; w0 = EID;
        launch(1'b0, 1'b0); drain();

        for (int i = 0; i < 20; i++) begin
            w0      = ($urandom_range(0, 1) == 0) ? EID : $urandom;
            w1      = ($urandom_range(0, 1) == 0) ? ETS : $urandom;
            plan_id = $urandom_range(0, 6);
            plan_ts = $urandom_range(0, 6);
            launch(1'b0, $urandom_range(0, 1) == 1);
            drain();
        end

        w0 = $urandom; w1 = ETS; plan_id = 0; plan_ts = 0;
        launch(1'b0, 1'b0);
        repeat (4) @(negedge clock);
        chk("busy_before_rst", 1, busy_s[1], 1'b1);
        reset = 1'b1;
        #1;
        check_zero_outputs();
        sb.delete();
        for (int d = 0; d < 2; d++) begin
            last_id[d] = 32'h0000_0000;
            last_ts[d] = 32'h0000_0000;
        end
        repeat (2) @(negedge clock);
        launch(1'b1, 1'b0); drain();
        w0 = EID; w1 = ETS;
        launch(1'b0, 1'b1); drain();
        w0 = 32'h0000_0001;
        launch(1'b0, 1'b0); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
